// File: rtl/flow_pkg.sv
// Shared constants and types for the transmit-side flow-control consumer.
package flow_pkg;

    localparam int NUM_VC         = 4;
    localparam int VC_IDX_W       = 2;
    localparam int DEFAULT_WEIGHT = 0;

    // Bit position of each state inside the one-hot state vector
    localparam int S_RESET_IDX  = 0;
    localparam int S_CONFIG_IDX = 1;
    localparam int S_RUN_IDX    = 2;
    localparam int S_ERROR_IDX  = 3;

    typedef enum logic [3:0] {
        ST_RESET  = 4'(1 << S_RESET_IDX),
        ST_CONFIG = 4'(1 << S_CONFIG_IDX),
        ST_RUN    = 4'(1 << S_RUN_IDX),
        ST_ERROR  = 4'(1 << S_ERROR_IDX)
    } state_t;

    // Turns a VC index into a one-hot VC mask
    function automatic logic [NUM_VC-1:0] idx_to_onehot(input logic [VC_IDX_W-1:0] idx);
        return NUM_VC'(1) << idx;
    endfunction

endpackage

// File: rtl/flow_tx_wrr_arbiter.sv
// Weighted round-robin arbiter: owns the turn pointer and the per-turn
// credit counter, and finds the next eligible VC in cyclic order.
module wrr_arbiter
    import flow_pkg::*;
#(
    parameter int WEIGHT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       advance,
    input  logic [NUM_VC-1:0]          eligible,
    input  logic [NUM_VC*WEIGHT_W-1:0] weights,
    output logic [NUM_VC-1:0]          grant,
    output logic [VC_IDX_W-1:0]        grant_idx,
    output logic                       grant_valid
);

    // Credit must hold weight+1, so it is one bit wider than a weight
    localparam int CRED_W = WEIGHT_W + 1;

    logic [VC_IDX_W-1:0] ptr;
    logic [VC_IDX_W-1:0] ptr_n;
    logic [CRED_W-1:0]   credit;
    logic [CRED_W-1:0]   credit_n;
    logic [CRED_W-1:0]   turn_credit;
    logic [VC_IDX_W-1:0] after_idx;

    // Full credit for one turn of a VC: its weight plus one word
    function automatic logic [CRED_W-1:0] full_credit(
        input logic [NUM_VC*WEIGHT_W-1:0] w,
        input logic [VC_IDX_W-1:0]        idx
    );
        return CRED_W'(w[idx*WEIGHT_W +: WEIGHT_W]) + CRED_W'(1);
    endfunction

    // Cyclic search from the pointer; scanning far-to-near lets the nearest eligible VC win
    always_comb begin
        grant_idx   = ptr;
        grant_valid = 1'b0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (eligible[2'(ptr + 2'(k))]) begin
                grant_idx   = 2'(ptr + 2'(k));
                grant_valid = 1'b1;
            end
        end
        grant = grant_valid ? idx_to_onehot(grant_idx) : '0;
    end

    // Next pointer/credit after a pop; a skipped-to VC starts a fresh turn and this pop is its first word
    always_comb begin
        turn_credit = (grant_idx == ptr) ? credit : full_credit(weights, grant_idx);
        after_idx   = 2'(grant_idx + 2'd1);
        ptr_n       = grant_idx;
        credit_n    = turn_credit - CRED_W'(1);
        if (turn_credit == CRED_W'(1)) begin
            ptr_n    = after_idx;
            credit_n = full_credit(weights, after_idx);
        end
    end

    // Pointer and credit registers, restarted at VC0 when transmission begins
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            credit <= CRED_W'(1);
        end else if (start) begin
            ptr    <= '0;
            credit <= full_credit(weights, '0);
        end else if (advance && grant_valid) begin
            ptr    <= ptr_n;
            credit <= credit_n;
        end
    end

endmodule

// File: rtl/flow_tx.sv
// Transmit-side flow-control consumer: drains four VC FIFOs into one
// registered stream under WRR arbitration, honouring per-VC pauses.
module flow_tx
    import flow_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int WEIGHT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       iniciar,
    input  logic                       cfg_load,
    input  logic [NUM_VC*WEIGHT_W-1:0] cfg_weights,
    input  logic [NUM_VC-1:0]          pausa,
    input  logic [NUM_VC-1:0]          continuar,
    input  logic [NUM_VC-1:0]          error_full,
    input  logic                       idle,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_VC*DATA_W-1:0]   vc_data,
    output logic [NUM_VC-1:0]          vc_pop,
    output logic [DATA_W-1:0]          tx_data,
    output logic [VC_IDX_W-1:0]        tx_vc,
    output logic                       tx_valid,
    output logic                       stalled,
    output logic                       error
);

    state_t                     state;
    state_t                     state_n;
    logic [NUM_VC-1:0]          paused;
    logic [NUM_VC-1:0]          eligible;
    logic [NUM_VC-1:0]          grant;
    logic [VC_IDX_W-1:0]        grant_idx;
    logic                       grant_valid;
    logic [NUM_VC*WEIGHT_W-1:0] weights;
    logic                       pop_en;
    logic                       arb_start;

    assign eligible = ~vc_empty & ~paused;
    assign vc_pop   = pop_en ? grant : '0;

    wrr_arbiter #(
        .WEIGHT_W (WEIGHT_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .start       (arb_start),
        .advance     (pop_en),
        .eligible    (eligible),
        .weights     (weights),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next state and per-state outputs; an overflow error in RUN wins over any pop
    always_comb begin
        state_n   = state;
        pop_en    = 1'b0;
        arb_start = 1'b0;
        stalled   = 1'b0;
        error     = 1'b0;
        unique case (state)
            ST_RESET: begin
                state_n = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (iniciar) begin
                    state_n   = ST_RUN;
                    arb_start = enb;
                end
            end
            ST_RUN: begin
                stalled = (vc_empty != '1) && !grant_valid;
                if (error_full != '0) begin
                    state_n = ST_ERROR;
                end else begin
                    pop_en = enb && rst;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_n = ST_RESET;
            end
        endcase
    end

    // State register; enb low freezes the FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RESET;
        end else if (enb) begin
            state <= state_n;
        end
    end

    // Arbitration weight table, writable only while configuring
    always_ff @(posedge clk) begin
        if (!rst) begin
            weights <= {NUM_VC{WEIGHT_W'(DEFAULT_WEIGHT)}};
        end else if (enb && state == ST_CONFIG && cfg_load) begin
            weights <= cfg_weights;
        end
    end

    // Pause flags: a pause request beats a simultaneous resume or idle release
    always_ff @(posedge clk) begin
        if (!rst) begin
            paused <= '0;
        end else if (enb) begin
            paused <= pausa | (paused & ~(continuar | {NUM_VC{idle}}));
        end
    end

    // Output stage: the popped head word appears one cycle after its pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_vc    <= '0;
        end else if (enb) begin
            tx_valid <= |vc_pop;
            if (|vc_pop) begin
                tx_data <= vc_data[grant_idx*DATA_W +: DATA_W];
                tx_vc   <= grant_idx;
            end
        end else begin
            tx_valid <= 1'b0;
        end
    end

endmodule
